button_conditioner: RTL and testbench

//   N-channel push-button front end for the alarm-clock UI: synchroniser, debouncer,

---
 rtl/btn_pkg.sv | 26 ++
 rtl/btn_channel.sv | 149 ++++++++++++++
 rtl/button_conditioner.sv | 48 ++++
 tb/tb_button_conditioner.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the repeat-FSM state encoding, the default timing constants for the
// 100 MHz board clock, and a helper that sizes counters from their maximum value.
package btn_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam int DEF_N_BTN           = 5;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 2**20;   // ~10 ms
    localparam int DEF_REPEAT_DELAY    = 2**25;   // ~335 ms
    localparam int DEF_REPEAT_RATE     = 2**23;   // ~84 ms

    // Bits needed to hold 0..max_count; never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debouncer, edge pulses and auto-repeat.
// Latency: input step sampled at edge k shows on btn_level at k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
// Backpressure: none; pulses are single-cycle strobes that the consumer must take.
//
// Ports: clk, rst (async active-low), btn_in (raw pin), repeat_en (sync),
//        btn_level / press_pulse / release_pulse / act_pulse (all registered).
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic act_pulse
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("btn_channel: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
        $error("btn_channel: DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_chk_rpt
        $error("btn_channel: REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY - 1 : REPEAT_RATE - 1;
    localparam int RP_W   = cnt_width(RP_MAX);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RR_LAST = RP_W'(REPEAT_RATE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   act_q, act_d;
    rpt_state_t             state_q, state_d;
    logic [RP_W-1:0]        rcnt_q, rcnt_d;
    logic                   sync_s;
    logic                   strobe;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
    assign sync_s = sync_q[SYNC_STAGES-1];

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        db_cnt_d  = db_cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync_s == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d  = '0;
            level_d   = ~level_q;
            press_d   = ~level_q;
            release_d = level_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Repeat FSM. It looks at the next level (level_d) so that a release
    // accepted on this edge suppresses a strobe falling due on the same edge,
    // and it leaves IDLE on the same edge the press is accepted so the first
    // strobe lands exactly REPEAT_DELAY edges after press_pulse.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        strobe  = 1'b0;
        case (state_q)
            RPT_IDLE: begin
                if (press_d && repeat_en) begin
                    state_d = RPT_DELAY;
                    rcnt_d  = '0;
                end
            end
            RPT_DELAY: begin
                if (!level_d || !repeat_en) begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == RD_LAST) begin
                    strobe  = 1'b1;
                    state_d = RPT_REPEAT;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            RPT_REPEAT: begin
                if (!level_d || !repeat_en) begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == RR_LAST) begin
                    strobe = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RPT_IDLE;
                rcnt_d  = '0;
            end
        endcase
        act_d = press_d | strobe;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            act_q     <= 1'b0;
            state_q   <= RPT_IDLE;
            rcnt_q    <= '0;
        end else begin
            sync_q    <= sync_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            act_q     <= act_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign act_pulse     = act_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end: sync, debounce, press/release pulses, auto-repeat.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES-1 edges from pin sample to btn_level/press_pulse.
// Backpressure: none; outputs are registered single-cycle strobes per channel.
//
// Ports: clk, rst (async active-low), btn_in[N_BTN] raw pins (1 = pressed),
//        repeat_en[N_BTN], btn_level/press_pulse/release_pulse/act_pulse[N_BTN].
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] act_pulse
);

    if (N_BTN < 1) begin : g_chk_n
        $error("button_conditioner: N_BTN must be at least 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .btn_in       (btn_in[i]),
            .repeat_en    (repeat_en[i]),
            .btn_level    (btn_level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .act_pulse    (act_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
    localparam int N    = 5;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RR   = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in, repeat_en;
    logic [N-1:0] btn_level, press_pulse, release_pulse, act_pulse;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
        .btn_level(btn_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .act_pulse(act_pulse)
    );

    // Reference model: the level flips once the last DEB synchronised samples
    // all disagree with it; repeats are scheduled as absolute edge times.
    logic [N-1:0] m_lvl, m_press, m_rel, m_act, m_active;
    logic [N-1:0] m_hist[$];
    int           m_next[N];
    int           m_t;

    logic [4*N-1:0] obs, expv;
    assign obs  = {btn_level, press_pulse, release_pulse, act_pulse};
    assign expv = {m_lvl, m_press, m_rel, m_act};

    task automatic model_reset();
        m_hist.delete();
        m_lvl = '0; m_press = '0; m_rel = '0; m_act = '0; m_active = '0;
        m_t = 0;
        for (int c = 0; c < N; c++) m_next[c] = 0;
    endtask

    task automatic model_edge();
        logic flip, stb;
        m_hist.push_front(btn_in);
        if (m_hist.size() > SYNC + DEB) void'(m_hist.pop_back());
        for (int c = 0; c < N; c++) begin
            flip = (m_hist.size() == SYNC + DEB);
            for (int j = SYNC; j < SYNC + DEB; j++)
                if (m_hist[j][c] == m_lvl[c]) flip = 1'b0;
            m_press[c] = flip & ~m_lvl[c];
            m_rel[c]   = flip & m_lvl[c];
            if (flip) m_lvl[c] = ~m_lvl[c];
            stb = 1'b0;
            if (m_press[c] && repeat_en[c]) begin
                m_active[c] = 1'b1;
                m_next[c]   = m_t + RD;
            end else if (m_active[c] && (!m_lvl[c] || !repeat_en[c])) begin
                m_active[c] = 1'b0;
            end else if (m_active[c] && m_t == m_next[c]) begin
                stb       = 1'b1;
                m_next[c] = m_t + RR;
            end
            m_act[c] = m_press[c] | stb;
        end
        m_t++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; btn_in = '0; repeat_en = '0;
        model_reset();
        #13;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_state got=%h need=0", obs); end
        @(negedge clk); rst = 1'b1;
        for (int e = 0; e < 6; e++) begin
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL idle e=%0d got=%h need=%h", e, obs, expv); end
        end
    endtask

    task automatic test_clean_press();
        int pe = -1, pc = 0, re = -1;
        btn_in[0] = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL clean_press e=%0d got=%h need=%h", e, obs, expv); end
            if (press_pulse[0] && act_pulse[0]) begin pc++; if (pe < 0) pe = e; end
        end
        total++;
        if (pe != 5 || pc != 1) begin bad++; $display("FAIL press_latency got edge=%0d count=%0d need edge=5 count=1", pe, pc); end
        btn_in[0] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL clean_release e=%0d got=%h need=%h", e, obs, expv); end
            if (release_pulse[0] && re < 0) re = e;
        end
        total++;
        if (re != 5) begin bad++; $display("FAIL release_latency got edge=%0d need 5", re); end
    endtask

    task automatic test_bounce();
        logic [7:0] pat = 8'b1111_0111;   // bit e is the sample for edge e: 1,1,1,0,1,1,1,1
        int pe = -1, pc = 0, hi = 0;
        for (int e = 0; e < 18; e++) begin
            btn_in[1] = (e < 8) ? pat[e] : 1'b1;
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL bounce e=%0d got=%h need=%h", e, obs, expv); end
            if (press_pulse[1]) begin pc++; if (pe < 0) pe = e; end
        end
        total++;
        if (pe != 9 || pc != 1) begin bad++; $display("FAIL bounce_press got edge=%0d count=%0d need edge=9 count=1", pe, pc); end
        btn_in[1] = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        for (int e = 0; e < 24; e++) begin
            btn_in[1] = ((e % 4) != 3);   // 3-cycle high glitches
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL glitch e=%0d got=%h need=%h", e, obs, expv); end
            if (btn_level[1]) hi++;
        end
        btn_in[1] = 1'b0;
        total++;
        if (hi != 0) begin bad++; $display("FAIL glitch_level got high_cycles=%0d need 0", hi); end
        for (int e = 0; e < 8; e++) tick();
    endtask

    task automatic test_repeat();
        int got[$];
        int want[$];
        int viol = 0;
        repeat_en[2] = 1'b1; btn_in[2] = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL repeat e=%0d got=%h need=%h", e, obs, expv); end
            if (act_pulse[2]) got.push_back(e);
        end
        want.push_back(5);
        for (int t = 5 + RD; t < 30; t += RR) want.push_back(t);
        total++;
        if (got != want) begin bad++; $display("FAIL repeat_times got n=%0d need n=%0d (5,15,18,...)", got.size(), want.size()); end
        btn_in[2] = 1'b0;
        for (int e = 0; e < 15; e++) begin
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL repeat_release e=%0d got=%h need=%h", e, obs, expv); end
            if (!btn_level[2] && act_pulse[2]) viol++;
        end
        total++;
        if (viol != 0 || btn_level[2] !== 1'b0) begin bad++; $display("FAIL strobe_after_release got=%0d lvl=%b need 0 0", viol, btn_level[2]); end
        repeat_en[2] = 1'b0;
    endtask

    task automatic test_repeat_disable();
        int got[$];
        int want[$] = '{5, 15};
        btn_in[3] = 1'b1;
        for (int e = 0; e < 40; e++) begin
            repeat_en[3] = !(e >= 16 && e < 24);
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL disable e=%0d got=%h need=%h", e, obs, expv); end
            if (act_pulse[3]) got.push_back(e);
        end
        total++;
        if (got != want) begin bad++; $display("FAIL disable_times got n=%0d need n=2 (5,15)", got.size()); end
        btn_in[3] = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        got.delete();
        repeat_en[3] = 1'b0; btn_in[3] = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL no_en e=%0d got=%h need=%h", e, obs, expv); end
            if (act_pulse[3]) got.push_back(e);
        end
        total++;
        if (got.size() != 1 || got[0] != 5) begin bad++; $display("FAIL no_en_acts got n=%0d need only edge 5", got.size()); end
        btn_in[3] = 1'b0;
        for (int e = 0; e < 10; e++) tick();
    endtask

    task automatic test_reset_mid();
        int pe = -1;
        repeat_en[2] = 1'b1; btn_in[2] = 1'b1;
        for (int e = 0; e < 8; e++) tick();
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL async_reset got=%h need=0", obs); end
        @(negedge clk); rst = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL after_reset e=%0d got=%h need=%h", e, obs, expv); end
            if (press_pulse[2] && pe < 0) pe = e;
        end
        total++;
        if (pe != 5) begin bad++; $display("FAIL reset_repress got edge=%0d need 5", pe); end
        btn_in[2] = 1'b0; repeat_en[2] = 1'b0;
        for (int e = 0; e < 10; e++) tick();
    endtask

    task automatic test_all_channels();
        int hold[N];
        repeat_en = N'($urandom);
        for (int c = 0; c < N; c++) hold[c] = $urandom_range(12, 34);
        for (int e = 0; e < 50; e++) begin
            for (int c = 0; c < N; c++) btn_in[c] = (e < hold[c]);
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL all_ch e=%0d got=%h need=%h", e, obs, expv); end
            if (e == 5) begin
                total++;
                if (press_pulse !== {N{1'b1}} || act_pulse !== {N{1'b1}})
                begin bad++; $display("FAIL simultaneous got press=%b act=%b need all ones", press_pulse, act_pulse); end
            end
        end
    endtask

    task automatic test_random();
        int run[N];
        for (int c = 0; c < N; c++) run[c] = 0;
        for (int e = 0; e < 600; e++) begin
            for (int c = 0; c < N; c++) begin
                if (run[c] == 0) begin
                    btn_in[c] = 1'($urandom_range(0, 1));
                    run[c] = $urandom_range(1, 20);
                end
                run[c]--;
            end
            if ($urandom_range(0, 15) == 0) repeat_en = N'($urandom);
            tick();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL random e=%0d got=%h need=%h", e, obs, expv); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_repeat_disable();
        test_reset_mid();
        test_all_channels();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
